// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small ALU with a single
// registered result slot (valid/ready on both sides, 1-cycle latency).
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_id;
    logic             r_last;

    logic             w_slot_free;
    logic             w_gnt_valid;
    logic             w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_alu;

    function automatic logic [WIDTH-1:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'd1:    res = a - b;
            3'd2:    res = a & b;
            3'd3:    res = a | b;
            3'd4:    res = a ^ b;
            default: res = a + b;
        endcase
        return res;
    endfunction

    // A FULL slot frees up in the same cycle the consumer drains it.
    assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;

    always_comb begin
        w_gnt_valid = req0_valid || req1_valid;
        w_gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    assign req0_ready = rst_n && w_slot_free && w_gnt_valid && (w_gnt_id == 1'b0);
    assign req1_ready = rst_n && w_slot_free && w_gnt_valid && (w_gnt_id == 1'b1);
    assign w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    assign w_a   = w_gnt_id ? req1_a  : req0_a;
    assign w_b   = w_gnt_id ? req1_b  : req0_b;
    assign w_op  = w_gnt_id ? req1_op : req0_op;
    assign w_alu = alu_f(w_op, w_a, w_b);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_accept) begin
            r_result <= w_alu;
            r_id     <= w_gnt_id;
            r_last   <= w_gnt_id;
        end
    end

    assign rsp_valid  = (r_state == S_FULL);
    assign rsp_result = r_result;
    assign rsp_id     = r_id;

endmodule
